// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// baud divider computation and the 2-of-3 sample vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  // Clocks per sample tick, truncated; never below one so the divider always ticks.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned over_sample);
    int unsigned div;
    div = clk_hz / (baud * over_sample);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // Majority of three samples, used to reject single-sample noise.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the receiver's serial input and byte-stream handshake, with the
// receiver (master) and consumer (slave) views.
interface uart_rx_if #(
  parameter int DataLength = 8
);
  logic                  rx;
  logic [DataLength-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Sample-tick divider: one registered tick every Div clocks, restartable so
// the receiver can align bit phase to a detected start edge.
module uart_baud_gen #(
  parameter int unsigned Div = 54
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  // Next count and tick; a restart zeroes the phase and suppresses the tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (i_restart) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Divider state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output, framing-error and
// overrun pulses. Bit decisions use a 3-sample majority around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DataLength      = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 50_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  output logic [DataLength-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic                  o_busy
);
  localparam int unsigned Div   = calc_div(SystemClockFreq, BaudRate, OverSample);
  localparam int          Half  = OverSample / 2;
  localparam int          TickW = $clog2(OverSample);
  localparam int          BitW  = (DataLength > 1) ? $clog2(DataLength) : 1;

  localparam logic [TickW-1:0] TickV0   = TickW'(Half - 1);
  localparam logic [TickW-1:0] TickV1   = TickW'(Half);
  localparam logic [TickW-1:0] TickV2   = TickW'(Half + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OverSample - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataLength - 1);

  uart_rx_state_t        state_q, state_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [TickW-1:0]      bit_tick_q, bit_tick_d;
  logic [TickW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [BitW-1:0]       bit_idx_q, bit_idx_d;
  logic [DataLength-1:0] shift_q, shift_d;
  logic [1:0]            vote_q, vote_d;
  logic [DataLength-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  logic rx_s, tick_s, restart_s, start_edge_s, decide_s, vote_s, good_stop_s;

  assign rx_s         = sync2_q;
  assign start_edge_s = prev_q & ~rx_s;
  assign decide_s     = tick_s && (bit_tick_q == TickV2);
  assign vote_s       = maj3(vote_q[0], vote_q[1], rx_s);
  assign good_stop_s  = (state_q == ST_STOP) && decide_s && vote_s;

  uart_baud_gen #(.Div(Div)) u_baud_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (restart_s),
    .o_tick    (tick_s)
  );

  // Next-state logic: bit timing, sampling, FSM and output handshake.
  always_comb begin
    state_d     = state_q;
    bit_tick_d  = bit_tick_q;
    idle_cnt_d  = idle_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    vote_d      = vote_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    restart_s   = 1'b0;

    if (tick_s) begin
      bit_tick_d = (bit_tick_q == TickLast) ? '0 : bit_tick_q + TickW'(1);
      if (bit_tick_q == TickV0) begin
        vote_d[0] = rx_s;
      end else if (bit_tick_q == TickV1) begin
        vote_d[1] = rx_s;
      end else begin
        vote_d = vote_q;
      end
    end else begin
      bit_tick_d = bit_tick_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d    = ST_START;
          restart_s  = 1'b1;
          bit_tick_d = '0;
          bit_idx_d  = '0;
          vote_d     = 2'b00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s) begin
          state_d   = vote_s ? ST_IDLE : ST_DATA;
          bit_idx_d = '0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_d = DataLength'({vote_s, shift_q} >> 1);
          if (bit_idx_q == BitLast) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BitW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          if (vote_s) begin
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            idle_cnt_d  = '0;
            state_d     = ST_WAIT_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        // Line must stay high for a whole bit before a new frame is accepted.
        if (tick_s) begin
          if (!rx_s) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == TickLast) begin
            idle_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + TickW'(1);
          end
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new byte wins over a transfer; if the holding slot is stuck, drop it.
    if (good_stop_s) begin
      if (!rx_valid_q || i_rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && i_rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs; synchronizer idles high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_IDLE;
      bit_tick_q  <= '0;
      idle_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      vote_q      <= 2'b00;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= i_rx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      bit_tick_q  <= bit_tick_d;
      idle_cnt_q  <= idle_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      vote_q      <= vote_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;

endmodule
